// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronizes rx, samples each bit at mid-bit using divisor k,
// and publishes the character plus sticky RXRDY/FERR/PERR/OVF status.
module uart_rx_deframer #(
  parameter int KW          = 19,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  input  logic          eight,
  input  logic          pen,
  input  logic          even,
  input  logic          clr,
  input  logic [KW-1:0] k,
  output logic [7:0]    data,
  output logic          rxrdy,
  output logic          ferr,
  output logic          perr,
  output logic          ovf
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                rxs, rxs_q;
  logic [KW-1:0]       cnt, k_f;
  logic                eight_f, pen_f, even_f;
  logic [2:0]          idx;
  logic [7:0]          shreg;
  logic                par_acc, par_bad;
  logic                expire, start_frame, load_full, sample_data, sample_par, complete;

  assign rxs    = sync_q[SYNC_STAGES-1];
  assign expire = (cnt == KW'(1));

  // Synchronizer and previous-sample register preset high so reset never looks like a start edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      rxs_q  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      rxs_q  <= rxs;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // A start needs a falling edge, so a held break does not retrigger frames
  always_comb begin
    state_n     = state;
    start_frame = 1'b0;
    load_full   = 1'b0;
    sample_data = 1'b0;
    sample_par  = 1'b0;
    complete    = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs && rxs_q) begin
          start_frame = 1'b1;
          state_n     = START;
        end
      end
      START: begin
        if (expire) begin
          if (rxs) begin
            state_n = IDLE;
          end else begin
            load_full = 1'b1;
            state_n   = DATA;
          end
        end
      end
      DATA: begin
        if (expire) begin
          sample_data = 1'b1;
          load_full   = 1'b1;
          if (idx == (eight_f ? 3'd7 : 3'd6))
            state_n = pen_f ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (expire) begin
          sample_par = 1'b1;
          load_full  = 1'b1;
          state_n    = STOP;
        end
      end
      STOP: begin
        if (expire) begin
          complete = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      k_f     <= '0;
      eight_f <= 1'b0;
      pen_f   <= 1'b0;
      even_f  <= 1'b0;
      idx     <= 3'd0;
      shreg   <= 8'h00;
      par_acc <= 1'b0;
      par_bad <= 1'b0;
    end else begin
      if (start_frame) begin
        cnt     <= k >> 1;
        k_f     <= k;
        eight_f <= eight;
        pen_f   <= pen;
        even_f  <= even;
        par_acc <= 1'b0;
        par_bad <= 1'b0;
      end else if (load_full) begin
        cnt <= k_f;
      end else if (state != IDLE) begin
        cnt <= cnt - KW'(1);
      end
      if (state == START) idx <= 3'd0;
      else if (sample_data) idx <= idx + 3'd1;
      if (sample_data) begin
        shreg   <= {rxs, shreg[7:1]};
        par_acc <= par_acc ^ rxs;
      end
      if (sample_par)
        par_bad <= (rxs != (even_f ? par_acc : ~par_acc));
    end
  end

  // Completion beats a simultaneous clr; in that case the old rxrdy does not count as overrun
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data  <= 8'h00;
      rxrdy <= 1'b0;
      ferr  <= 1'b0;
      perr  <= 1'b0;
      ovf   <= 1'b0;
    end else if (complete) begin
      data  <= eight_f ? shreg : {1'b0, shreg[7:1]};
      rxrdy <= 1'b1;
      ferr  <= ~rxs;
      perr  <= pen_f & par_bad;
      ovf   <= clr ? 1'b0 : (ovf | rxrdy);
    end else if (clr) begin
      rxrdy <= 1'b0;
      ferr  <= 1'b0;
      perr  <= 1'b0;
      ovf   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed self-checking bench for uart_rx_deframer: framing variants, status bits,
// overrun/clr collision, glitch, break and mid-frame reset.
module tb_uart_rx_deframer;

  localparam int KW = 19;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx;
  logic          eight, pen, even, clr;
  logic [KW-1:0] k;
  logic [7:0]    data;
  logic          rxrdy, ferr, perr, ovf;

  int tests = 0;
  int fails = 0;

  uart_rx_deframer #(.KW(KW), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .rx(rx), .eight(eight), .pen(pen), .even(even),
    .clr(clr), .k(k), .data(data), .rxrdy(rxrdy), .ferr(ferr), .perr(perr), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulseClr();
    clr = 1'b1;
    idleCycles(1);
    clr = 1'b0;
  endtask

  // Drives start, data (LSB first) and parity; leaves rx at the stop value just as the stop bit begins
  task automatic startFrame(input logic [7:0] val, input int nbits, input bit par_en,
                            input bit par_bit, input bit stop_bit, input int kk);
    rx = 1'b0;
    idleCycles(kk);
    for (int i = 0; i < nbits; i++) begin
      rx = val[i];
      idleCycles(kk);
    end
    if (par_en) begin
      rx = par_bit;
      idleCycles(kk);
    end
    rx = stop_bit;
  endtask

  // Two synchronizer cycles plus half a bit lands on the stop-sample cycle
  task automatic toStopSample(input int kk);
    idleCycles(2 + kk / 2);
  endtask

  task automatic endFrame(input int kk);
    idleCycles(kk - 2 - kk / 2);
    rx = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] val, input int nbits, input bit par_en,
                               input bit par_bit, input bit stop_bit, input int kk);
    startFrame(val, nbits, par_en, par_bit, stop_bit, kk);
    toStopSample(kk);
    endFrame(kk);
  endtask

  initial begin
    reset = 1'b1; rx = 1'b1; clr = 1'b0;
    eight = 1'b1; pen = 1'b0; even = 1'b0; k = KW'(868);
    idleCycles(3);
    reset = 1'b0;
    idleCycles(2);
    checkOutput("rst_data", data, 8'h00);
    checkOutput("rst_rxrdy", rxrdy, 0);
    checkOutput("rst_ferr", ferr, 0);
    checkOutput("rst_perr", perr, 0);
    checkOutput("rst_ovf", ovf, 0);

    // 8N1, k=868, 0x55 with latency check around the stop sample
    startFrame(8'h55, 8, 0, 0, 1, 868);
    toStopSample(868);
    checkOutput("lat_before", rxrdy, 0);
    idleCycles(1);
    checkOutput("lat_after", rxrdy, 1);
    checkOutput("n81_data", data, 8'h55);
    checkOutput("n81_ferr", ferr, 0);
    checkOutput("n81_perr", perr, 0);
    checkOutput("n81_ovf", ovf, 0);
    idleCycles(868);
    pulseClr();
    checkOutput("clr_rxrdy", rxrdy, 0);
    checkOutput("clr_data", data, 8'h55);

    // 8E1 / 7O1 parity, k=16
    k = KW'(16); pen = 1'b1; even = 1'b1; eight = 1'b1;
    applyStimulus(8'hA5, 8, 1, 0, 1, 16);
    idleCycles(20);
    checkOutput("e81_data", data, 8'hA5);
    checkOutput("e81_rxrdy", rxrdy, 1);
    checkOutput("e81_perr_ok", perr, 0);
    pulseClr();
    applyStimulus(8'hA5, 8, 1, 1, 1, 16);
    idleCycles(20);
    checkOutput("e81_perr_bad", perr, 1);
    pulseClr();
    eight = 1'b0; even = 1'b0;
    applyStimulus(8'h41, 7, 1, 1, 1, 16);
    idleCycles(20);
    checkOutput("o71_data", data, 8'h41);
    checkOutput("o71_perr", perr, 0);
    pulseClr();

    // Framing error, 8N1
    eight = 1'b1; pen = 1'b0;
    applyStimulus(8'h3C, 8, 0, 0, 0, 16);
    idleCycles(20);
    checkOutput("fe_data", data, 8'h3C);
    checkOutput("fe_ferr", ferr, 1);
    checkOutput("fe_rxrdy", rxrdy, 1);
    pulseClr();

    // Back-to-back overrun, then clr colliding with completion
    applyStimulus(8'h11, 8, 0, 0, 1, 16);
    applyStimulus(8'h22, 8, 0, 0, 1, 16);
    idleCycles(20);
    checkOutput("b2b_data", data, 8'h22);
    checkOutput("b2b_ovf", ovf, 1);
    checkOutput("b2b_ferr", ferr, 0);
    startFrame(8'h33, 8, 0, 0, 1, 16);
    toStopSample(16);
    clr = 1'b1;
    idleCycles(1);
    clr = 1'b0;
    checkOutput("coll_rxrdy", rxrdy, 1);
    checkOutput("coll_ovf", ovf, 0);
    checkOutput("coll_data", data, 8'h33);
    idleCycles(20);
    pulseClr();

    // Break: held low through and past a frame
    rx = 1'b0;
    idleCycles(16 * 12);
    checkOutput("brk_data", data, 8'h00);
    checkOutput("brk_ferr", ferr, 1);
    checkOutput("brk_rxrdy", rxrdy, 1);
    pulseClr();
    idleCycles(200);
    checkOutput("brk_norestart", rxrdy, 0);
    rx = 1'b1;
    idleCycles(40);

    // 5-cycle glitch rejected, then valid frame
    rx = 1'b0;
    idleCycles(5);
    rx = 1'b1;
    idleCycles(60);
    checkOutput("glitch_rxrdy", rxrdy, 0);
    checkOutput("glitch_ferr", ferr, 0);
    applyStimulus(8'h7E, 8, 0, 0, 1, 16);
    idleCycles(20);
    checkOutput("post_glitch_data", data, 8'h7E);
    checkOutput("post_glitch_rxrdy", rxrdy, 1);
    checkOutput("post_glitch_ferr", ferr, 0);

    // Reset during data bit 4 of 0xF5 (bits 4..7 high, so the remainder has no falling edge)
    rx = 1'b0;
    idleCycles(16);
    for (int i = 0; i < 4; i++) begin
      rx = ((8'hF5 >> i) & 8'h01) != 0;
      idleCycles(16);
    end
    rx = 1'b1;
    idleCycles(8);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_data", data, 8'h00);
    checkOutput("mid_rst_rxrdy", rxrdy, 0);
    checkOutput("mid_rst_ovf", ovf, 0);
    idleCycles(1);
    reset = 1'b0;
    idleCycles(16 * 5 + 40);
    checkOutput("mid_rst_ignored", rxrdy, 0);
    applyStimulus(8'hC3, 8, 0, 0, 1, 16);
    idleCycles(20);
    checkOutput("after_rst_data", data, 8'hC3);
    checkOutput("after_rst_rxrdy", rxrdy, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Serial receive engine for the UART peripheral. Deframes asynchronous frames on rx into parallel bytes and drives the status bits the processor reads on the status port (RXRDY, FERR, PERR, OVF).
- Framing is selected at run time (7/8 data bits, parity on/off, even/odd). It uses the same bit-time divisor k as the transmit engine, so both directions share one baud setting.
- It is the receiving end of the framing the transmit engine produces.

Parameters:
- KW, 19, width of bit-time divisor k.
- SYNC_STAGES, 2, number of flip-flop stages on rx before the sampling logic (minimum 2).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx  in  1  serial line; idle high; asynchronous to clk
- eight  in  1  1 = 8 data bits, 0 = 7 data bits
- pen  in  1  1 = parity bit present after the data bits
- even  in  1  1 = even parity, 0 = odd parity
- clr  in  1  one-cycle pulse that clears rxrdy, ferr, perr and ovf
- k  in  KW  bit time in clk cycles; legal range 16..2^KW-1
- data  out  8  last received character; bit 7 = 0 in 7-bit mode
- rxrdy  out  1  a character is available
- ferr  out  1  stop bit of the last frame sampled low
- perr  out  1  parity mismatch on the last frame (only when pen = 1)
- ovf  out  1  a frame completed while rxrdy was already 1

Behaviour:
- Reset (asynchronous):
  - data = 0x00; rxrdy = ferr = perr = ovf = 0.
  - FSM = IDLE; synchronizer stages preset to 1.
  - Reset mid-frame abandons the frame; no status bit is set.
- Synchronizer: rx passes through SYNC_STAGES flip-flops; all further logic uses the synchronized value rxs.
- FSM states:
  - IDLE: wait for rxs = 0.
    - Latch k, eight, pen and even into frame registers. Changes to these inputs mid-frame are ignored.
    - Load the bit counter with k>>1 and go to START.
  - START: at the end of the half bit, sample rxs.
    - If rxs = 1, treat it as a false start and return to IDLE.
    - Otherwise load the bit counter with k, set the bit index to 0 and go to DATA.
  - DATA: sample rxs each time the counter expires (every k cycles, at mid-bit).
    - Shift received bits in LSB first.
    - Leave after 7 or 8 samples (per latched eight): go to PARITY if pen = 1, else to STOP.
  - PARITY: sample one bit. Expected bit = XOR of the data bits if even = 1, or XNOR of the data bits if even = 0.
  - STOP: sample the stop bit at mid-bit, then return to IDLE the same cycle. The remaining half stop bit is not waited out, so back-to-back frames resynchronize on the next falling edge.
- Bit counter: down-counter of width KW. It expires when it reaches 1, so the interval is exactly k cycles.
- Completion (the cycle after the stop sample):
  - data = received bits; the upper bit is forced to 0 in 7-bit mode.
  - rxrdy = 1.
  - ferr = ~stop_sample.
  - perr = pen & (parity_sample != expected).
  - ovf = 1 if rxrdy was already 1; data is overwritten with the new character.
- Latency: rxrdy rises 1 cycle after the mid-stop sample. Measured from the first synchronized low, that is (k>>1) + k*(n_data + pen + 1) + 1 cycles.
- Status bits are sticky until clr.
  - clr on the same cycle as completion: completion wins. rxrdy, ferr and perr take the new frame's values; ovf is the new frame's ovf only, not OR'ed with the old value.
  - clr in any other cycle: all four status bits = 0. data is unchanged.
- Glitch rejection: a low pulse shorter than k/2 cycles is rejected by the START check and leaves no state.
- A break (rx held low through the whole frame) gives data = 0x00, ferr = 1. The FSM stays in IDLE until rxs returns high, then waits for the next falling edge; it does not restart on a continuous low.

Test Plan:
- 8N1, k = 868, send 0x55 → rxrdy rises 1 cycle after the mid-stop sample; data = 0x55; ferr = perr = ovf = 0; clr → all status bits 0, data still 0x55.
- 8E1 (eight = 1, pen = 1, even = 1), k = 16, send 0xA5 with parity bit 0 → data = 0xA5, perr = 0. Repeat with parity bit 1 → perr = 1. Repeat in 7O1 sending 0x41 → data = 0x41, perr = 0 with the correct odd parity bit.
- Stop bit driven 0 on 0x3C, k = 16 → data = 0x3C, ferr = 1, rxrdy = 1.
- Two back-to-back 8N1 frames (0x11, 0x22) without clr → data = 0x22, ovf = 1. Third frame with clr asserted on its completion cycle → rxrdy = 1, ovf = 0.
- 5-cycle low glitch with k = 16 → FSM back in IDLE, no status change. A subsequent valid frame 0x7E is received correctly.
- Assert reset at DATA bit index 4 of a frame → all outputs 0 immediately. The rest of the frame is ignored. The next full frame 0xC3 → data = 0xC3, rxrdy = 1.
